// File: rtl/epp_pkg.sv
// EPP register arbiter shared definitions.
// FSM state encoding, bus widths and default synchronizer depth.
package epp_pkg;

    localparam int EPP_ADR_W       = 7;
    localparam int EPP_DATA_W      = 8;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [2:0] {
        RELEASE,
        IDLE,
        INT_GNT,
        ADR_ACC,
        DAT_ACC,
        RD_LAT,
        DONE
    } eppState_t;

    // Auto-increment wraps naturally at the address width (127 -> 0).
    function automatic logic [EPP_ADR_W-1:0] nextAdr(
        input logic [EPP_ADR_W-1:0] adr
    );
        return adr + EPP_ADR_W'(1);
    endfunction

endpackage

// File: rtl/epp_reg_arbiter_if.sv
// Register-bank command bus plus internal requester request/grant.
// master: arbiter side (drives command, grant); slave: bank/requester side.
interface epp_reg_arbiter_if;
    import epp_pkg::*;

    logic [EPP_ADR_W-1:0]  regAdr;
    logic [EPP_DATA_W-1:0] regWrData;
    logic                  regWe;
    logic                  regRe;
    logic [EPP_DATA_W-1:0] regRdData;
    logic                  intReq;
    logic                  intGnt;

    modport master (
        output regAdr,
        output regWrData,
        output regWe,
        output regRe,
        output intGnt,
        input  regRdData,
        input  intReq
    );

    modport slave (
        input  regAdr,
        input  regWrData,
        input  regWe,
        input  regRe,
        input  intGnt,
        output regRdData,
        output intReq
    );

endinterface

// File: rtl/epp_sync.sv
// N-stage, 3-bit synchronizer for the asynchronous EPP control pins.
// Ports: clk, rst_n (sync, active-low, resets to all-ones), d in, q out.
module epp_sync
    import epp_pkg::*;
#(
    parameter int N = SYNC_STAGES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] d,
    output logic [2:0] q
);

    logic [2:0] stage [N];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                stage[i] <= 3'b111;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < N; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[N-1];

endmodule

// File: rtl/epp_reg_arbiter.sv
// EPP host port to register-bank bridge, arbitrated against an internal requester.
// Ports: clk, rst_n, EppAstb/EppDstb/EppWr (async, active-low), DB (inout),
// EppWait (1 = transfer complete), bus (register command bus + intReq/intGnt).
module epp_reg_arbiter
    import epp_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   EppAstb,
    input  logic                   EppDstb,
    input  logic                   EppWr,
    inout  wire [EPP_DATA_W-1:0]   DB,
    output logic                   EppWait,
    epp_reg_arbiter_if.master      bus
);

    localparam int PRIME_W = $clog2(SYNC_STAGES + 1);

    eppState_t             state;
    logic [2:0]            syncQ;
    logic                  astbS;
    logic                  dstbS;
    logic                  wrS;
    logic [EPP_ADR_W-1:0]  adrReg;
    logic                  autoInc;
    logic [EPP_DATA_W-1:0] rdHold;
    logic                  dbOe;
    logic                  isData;
    logic                  isWr;
    logic [PRIME_W-1:0]    primeCnt;
    logic                  primed;
    logic [EPP_DATA_W-1:0] dbVal;

    epp_sync #(
        .N (SYNC_STAGES)
    ) uSync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({EppWr, EppDstb, EppAstb}),
        .q     (syncQ)
    );

    assign astbS = syncQ[0];
    assign dstbS = syncQ[1];
    assign wrS   = syncQ[2];

    // The synchronizer resets to "strobes high", so RELEASE must not trust
    // it until the real pin levels have propagated through every stage.
    // Otherwise a strobe held low across reset would look like a fresh edge.
    assign primed = (primeCnt == PRIME_W'(SYNC_STAGES));

    assign dbVal = isData ? rdHold : {autoInc, adrReg};
    assign DB    = dbOe ? dbVal : {EPP_DATA_W{1'bz}};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= RELEASE;
            EppWait       <= 1'b0;
            dbOe          <= 1'b0;
            bus.regWe     <= 1'b0;
            bus.regRe     <= 1'b0;
            bus.intGnt    <= 1'b0;
            bus.regAdr    <= '0;
            bus.regWrData <= '0;
            adrReg        <= '0;
            autoInc       <= 1'b0;
            rdHold        <= '0;
            isData        <= 1'b0;
            isWr          <= 1'b0;
            primeCnt      <= '0;
        end else begin
            // Command strobes are single-cycle pulses by default.
            bus.regWe <= 1'b0;
            bus.regRe <= 1'b0;

            if (!primed) begin
                primeCnt <= primeCnt + PRIME_W'(1);
            end

            unique case (state)
                RELEASE: begin
                    EppWait <= 1'b0;
                    dbOe    <= 1'b0;
                    if (primed && astbS && dstbS) begin
                        state <= IDLE;
                    end
                end

                IDLE: begin
                    // Host beats the internal requester; address beats data.
                    if (!astbS) begin
                        state  <= ADR_ACC;
                        isData <= 1'b0;
                        isWr   <= !wrS;
                        dbOe   <= wrS;
                    end else if (!dstbS) begin
                        state      <= DAT_ACC;
                        isData     <= 1'b1;
                        isWr       <= !wrS;
                        bus.regAdr <= adrReg;
                        if (!wrS) begin
                            bus.regWe     <= 1'b1;
                            bus.regWrData <= DB;
                        end else begin
                            bus.regRe <= 1'b1;
                        end
                    end else if (bus.intReq) begin
                        state      <= INT_GNT;
                        bus.intGnt <= 1'b1;
                    end
                end

                INT_GNT: begin
                    if (!bus.intReq) begin
                        state      <= IDLE;
                        bus.intGnt <= 1'b0;
                    end
                end

                ADR_ACC: begin
                    // A strobe already released means DB is no longer valid.
                    if (isWr && !astbS) begin
                        adrReg  <= DB[EPP_ADR_W-1:0];
                        autoInc <= DB[EPP_DATA_W-1];
                    end
                    EppWait <= 1'b1;
                    state   <= DONE;
                end

                DAT_ACC: begin
                    if (isWr) begin
                        EppWait <= 1'b1;
                        state   <= DONE;
                    end else begin
                        state <= RD_LAT;
                    end
                end

                RD_LAT: begin
                    rdHold  <= bus.regRdData;
                    dbOe    <= 1'b1;
                    EppWait <= 1'b1;
                    state   <= DONE;
                end

                DONE: begin
                    if (isData ? dstbS : astbS) begin
                        state   <= RELEASE;
                        EppWait <= 1'b0;
                        dbOe    <= 1'b0;
                        if (isData && autoInc) begin
                            adrReg <= nextAdr(adrReg);
                        end
                    end
                end

                default: begin
                    state <= RELEASE;
                end
            endcase
        end
    end

endmodule
